// File: rtl/ga23_sdr_arbiter_if.sv
// Layer-fetch and SDRAM read-channel signals of the GA23 background arbiter.
// The master side is the arbiter; the slave side is the layers plus the SDRAM controller.
interface ga23_sdr_arbiter_if;
   logic        l0_req;
   logic [21:0] l0_addr;
   logic [31:0] l0_data;
   logic        l0_rdy;
   logic        l1_req;
   logic [21:0] l1_addr;
   logic [31:0] l1_data;
   logic        l1_rdy;
   logic        l2_req;
   logic [21:0] l2_addr;
   logic [31:0] l2_data;
   logic        l2_rdy;
   logic        mem_req;
   logic [24:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;

   modport master (
      input  l0_req, l0_addr, l1_req, l1_addr, l2_req, l2_addr, mem_ack, mem_data,
      output l0_data, l0_rdy, l1_data, l1_rdy, l2_data, l2_rdy, mem_req, mem_addr
   );

   modport slave (
      output l0_req, l0_addr, l1_req, l1_addr, l2_req, l2_addr, mem_ack, mem_data,
      input  l0_data, l0_rdy, l1_data, l1_rdy, l2_data, l2_rdy, mem_req, mem_addr
   );
endinterface

// File: rtl/ga23_sdr_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port among the three GA23 background layers.
// One pending request per layer; the latest address wins; rows return with a one-cycle ready pulse.
module ga23_sdr_arbiter #(
   parameter logic [24:0] BASE_ADDR = 25'h0
) (
   input logic clk,
   input logic reset,
   ga23_sdr_arbiter_if.master bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [2:0]        pend_q, pend_d;
   logic [2:0][21:0]  addr_q, addr_d;
   logic [1:0]        cur_q, cur_d;
   logic [1:0]        last_q, last_d;
   logic              mem_req_q, mem_req_d;
   logic [24:0]       mem_addr_q, mem_addr_d;
   logic [2:0][31:0]  data_q, data_d;
   logic [2:0]        rdy_q, rdy_d;

   logic [2:0]        req;
   logic [2:0][21:0]  in_addr;
   logic [2:0]        pend_clr;
   logic [1:0]        grant;
   logic [1:0]        cand;
   logic              found;

   always_comb begin
      req     = {bus.l2_req, bus.l1_req, bus.l0_req};
      in_addr = {bus.l2_addr, bus.l1_addr, bus.l0_addr};

      state_d    = state_q;
      addr_d     = addr_q;
      cur_d      = cur_q;
      last_d     = last_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      data_d     = data_q;
      rdy_d      = '0;
      pend_clr   = '0;

      for (int unsigned n = 0; n < 3; n++) begin
         if (req[n]) addr_d[n] = in_addr[n];
      end

      // Search begins at the layer after the last one served, wrapping 2 -> 0.
      grant = '0;
      found = 1'b0;
      cand  = last_q;
      for (int unsigned k = 0; k < 3; k++) begin
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
         if (!found && pend_q[cand]) begin
            grant = cand;
            found = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               cur_d           = grant;
               pend_clr[grant] = 1'b1;
               mem_addr_d      = BASE_ADDR + {3'b000, addr_q[grant]};
               mem_req_d       = 1'b1;
               state_d         = BUSY;
            end
         end
         BUSY: begin
            if (bus.mem_ack) begin
               data_d[cur_q] = bus.mem_data;
               rdy_d[cur_q]  = 1'b1;
               last_d        = cur_q;
               mem_req_d     = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new request on the grant edge re-arms pend: set has priority over clear.
      pend_d = (pend_q & ~pend_clr) | req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         addr_q     <= '0;
         cur_q      <= '0;
         last_q     <= 2'd2;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         data_q     <= '0;
         rdy_q      <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         addr_q     <= addr_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         data_q     <= data_d;
         rdy_q      <= rdy_d;
      end
   end

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.l0_data  = data_q[0];
   assign bus.l1_data  = data_q[1];
   assign bus.l2_data  = data_q[2];
   assign bus.l0_rdy   = rdy_q[0];
   assign bus.l1_rdy   = rdy_q[1];
   assign bus.l2_rdy   = rdy_q[2];

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Directed bench for ga23_sdr_arbiter: a per-cycle vector table followed by
// hand-written round-robin, overwrite, re-request, same-edge and reset sequences.
module tb_ga23_sdr_arbiter;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   rdy_cnt [3];

   ga23_sdr_arbiter_if bus ();

   ga23_sdr_arbiter #(.BASE_ADDR(25'h100000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.l0_rdy) rdy_cnt[0]++;
      if (bus.l1_rdy) rdy_cnt[1]++;
      if (bus.l2_rdy) rdy_cnt[2]++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  req;
      logic [21:0] addr;
      logic        ack;
      logic [31:0] mdata;
      logic        exp_req;
      logic [24:0] exp_addr;
      logic [2:0]  exp_rdy;
      logic [31:0] exp_d0;
      logic [31:0] exp_d1;
      logic [31:0] exp_d2;
   } vec_t;

   vec_t vt [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse3(input logic [2:0] mask, input logic [21:0] a0,
                         input logic [21:0] a1, input logic [21:0] a2);
      bus.l0_req = mask[0]; bus.l0_addr = a0;
      bus.l1_req = mask[1]; bus.l1_addr = a1;
      bus.l2_req = mask[2]; bus.l2_addr = a2;
      tick();
      bus.l0_req = 1'b0; bus.l1_req = 1'b0; bus.l2_req = 1'b0;
   endtask

   function automatic logic [2:0] rdy_vec();
      return {bus.l2_rdy, bus.l1_rdy, bus.l0_rdy};
   endfunction

   function automatic logic [31:0] data_of(input int layer);
      case (layer)
         0:       return bus.l0_data;
         1:       return bus.l1_data;
         default: return bus.l2_data;
      endcase
   endfunction

   // Wait for a grant, check its address, ack after 3 cycles, then check the completion.
   task automatic serve(input int layer, input logic [24:0] exp_addr, input logic [31:0] d);
      int n;
      n = 0;
      while (!bus.mem_req && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("grant_seen_l%0d", layer), 64'(bus.mem_req), 64'd1);
      chk($sformatf("grant_addr_l%0d", layer), 64'(bus.mem_addr), 64'(exp_addr));
      tick();
      tick();
      chk($sformatf("hold_addr_l%0d", layer), 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, exp_addr}));
      bus.mem_ack  = 1'b1;
      bus.mem_data = d;
      tick();
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
      chk($sformatf("done_rdy_l%0d", layer), 64'(rdy_vec()), 64'(3'b001 << layer));
      chk($sformatf("done_data_l%0d", layer), 64'(data_of(layer)), 64'(d));
      chk($sformatf("done_req_low_l%0d", layer), 64'(bus.mem_req), 64'd0);
      tick();
      chk($sformatf("rdy_one_cycle_l%0d", layer), 64'(rdy_vec()), 64'd0);
   endtask

   initial begin
      int c0, c1, c2;
      total = 0;
      bad   = 0;
      for (int i = 0; i < 3; i++) rdy_cnt[i] = 0;
      bus.l0_req = 1'b0; bus.l0_addr = '0;
      bus.l1_req = 1'b0; bus.l1_addr = '0;
      bus.l2_req = 1'b0; bus.l2_addr = '0;
      bus.mem_ack = 1'b0; bus.mem_data = '0;

      //        req     addr      ack   mdata         ereq  eaddr       erdy    d0            d1            d2
      vt[0]  = '{3'b010, 22'h12344, 1'b0, 32'h0,        1'b0, 25'h0,      3'b000, 32'h0,        32'h0,        32'h0};
      vt[1]  = '{3'b000, 22'h0,     1'b0, 32'h0,        1'b1, 25'h112344, 3'b000, 32'h0,        32'h0,        32'h0};
      vt[2]  = '{3'b000, 22'h0,     1'b0, 32'h0,        1'b1, 25'h112344, 3'b000, 32'h0,        32'h0,        32'h0};
      vt[3]  = '{3'b000, 22'h0,     1'b1, 32'hDEADBEEF, 1'b0, 25'h0,      3'b010, 32'h0,        32'hDEADBEEF, 32'h0};
      vt[4]  = '{3'b000, 22'h0,     1'b0, 32'h0,        1'b0, 25'h0,      3'b000, 32'h0,        32'hDEADBEEF, 32'h0};
      vt[5]  = '{3'b000, 22'h0,     1'b1, 32'h12345678, 1'b0, 25'h0,      3'b000, 32'h0,        32'hDEADBEEF, 32'h0};
      vt[6]  = '{3'b001, 22'h00010, 1'b0, 32'h0,        1'b0, 25'h0,      3'b000, 32'h0,        32'hDEADBEEF, 32'h0};
      vt[7]  = '{3'b000, 22'h0,     1'b0, 32'h0,        1'b1, 25'h100010, 3'b000, 32'h0,        32'hDEADBEEF, 32'h0};
      vt[8]  = '{3'b000, 22'h0,     1'b1, 32'hCAFEF00D, 1'b0, 25'h0,      3'b001, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
      vt[9]  = '{3'b100, 22'h3FFFFF,1'b0, 32'h0,        1'b0, 25'h0,      3'b000, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
      vt[10] = '{3'b000, 22'h0,     1'b0, 32'h0,        1'b1, 25'h4FFFFF, 3'b000, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
      vt[11] = '{3'b000, 22'h0,     1'b1, 32'h00000001, 1'b0, 25'h0,      3'b100, 32'hCAFEF00D, 32'hDEADBEEF, 32'h00000001};

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("reset_mem_req", 64'(bus.mem_req), 64'd0);
      chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("reset_rdy", 64'(rdy_vec()), 64'd0);
      chk("reset_data", {bus.l0_data, bus.l1_data}, 64'd0);
      chk("reset_data2", 64'(bus.l2_data), 64'd0);

      for (int i = 0; i < 12; i++) begin
         bus.l0_req = vt[i].req[0]; bus.l0_addr = vt[i].addr;
         bus.l1_req = vt[i].req[1]; bus.l1_addr = vt[i].addr;
         bus.l2_req = vt[i].req[2]; bus.l2_addr = vt[i].addr;
         bus.mem_ack = vt[i].ack; bus.mem_data = vt[i].mdata;
         tick();
         bus.l0_req = 1'b0; bus.l1_req = 1'b0; bus.l2_req = 1'b0;
         bus.mem_ack = 1'b0; bus.mem_data = '0;
         chk($sformatf("vec%0d_mem_req", i), 64'(bus.mem_req), 64'(vt[i].exp_req));
         if (vt[i].exp_req)
            chk($sformatf("vec%0d_mem_addr", i), 64'(bus.mem_addr), 64'(vt[i].exp_addr));
         chk($sformatf("vec%0d_rdy", i), 64'(rdy_vec()), 64'(vt[i].exp_rdy));
         chk($sformatf("vec%0d_d0", i), 64'(bus.l0_data), 64'(vt[i].exp_d0));
         chk($sformatf("vec%0d_d1", i), 64'(bus.l1_data), 64'(vt[i].exp_d1));
         chk($sformatf("vec%0d_d2", i), 64'(bus.l2_data), 64'(vt[i].exp_d2));
      end

      // Round-robin: two simultaneous bursts after last_grant=2, each served 0,1,2.
      pulse3(3'b111, 22'h1, 22'h2, 22'h3);
      serve(0, 25'h100001, 32'h11111111);
      serve(1, 25'h100002, 32'h22222222);
      serve(2, 25'h100003, 32'h33333333);
      pulse3(3'b111, 22'h4, 22'h5, 22'h6);
      serve(0, 25'h100004, 32'h44444444);
      serve(1, 25'h100005, 32'h55555555);
      serve(2, 25'h100006, 32'h66666666);

      // Overwrite: layer 2 re-requested while layer 0 is in flight; only the latest address is fetched.
      c2 = rdy_cnt[2];
      pulse3(3'b001, 22'h20, 22'h0, 22'h0);
      tick();
      pulse3(3'b100, 22'h0, 22'h0, 22'h00100);
      pulse3(3'b100, 22'h0, 22'h0, 22'h00200);
      serve(0, 25'h100020, 32'hA0A0A0A0);
      serve(2, 25'h100200, 32'hB2B2B2B2);
      tick();
      tick();
      chk("overwrite_no_extra_grant", 64'(bus.mem_req), 64'd0);
      chk("overwrite_l2_rdy_count", 64'(rdy_cnt[2] - c2), 64'd1);

      // In-flight re-request of layer 0.
      c0 = rdy_cnt[0];
      pulse3(3'b001, 22'h30, 22'h0, 22'h0);
      tick();
      chk("inflight_busy", 64'(bus.mem_req), 64'd1);
      pulse3(3'b001, 22'h40, 22'h0, 22'h0);
      serve(0, 25'h100030, 32'hC0C0C0C0);
      serve(0, 25'h100040, 32'hC1C1C1C1);
      tick();
      tick();
      chk("inflight_l0_rdy_count", 64'(rdy_cnt[0] - c0), 64'd2);

      // Same-edge set/clear for layer 1.
      c1 = rdy_cnt[1];
      pulse3(3'b010, 22'h0, 22'h50, 22'h0);
      pulse3(3'b010, 22'h0, 22'h60, 22'h0);
      serve(1, 25'h100050, 32'hD0D0D0D0);
      serve(1, 25'h100060, 32'hD1D1D1D1);
      tick();
      tick();
      chk("same_edge_l1_rdy_count", 64'(rdy_cnt[1] - c1), 64'd2);

      // Reset mid-transfer, then a late ack and stray acks in IDLE.
      c0 = rdy_cnt[0]; c1 = rdy_cnt[1]; c2 = rdy_cnt[2];
      pulse3(3'b100, 22'h0, 22'h0, 22'h70);
      tick();
      chk("rst_pre_busy", 64'(bus.mem_req), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_async_mem_req", 64'(bus.mem_req), 64'd0);
      tick();
      reset = 1'b0;
      bus.mem_ack = 1'b1; bus.mem_data = 32'h0BAD0BAD;
      tick();
      bus.mem_ack = 1'b0; bus.mem_data = '0;
      tick();
      bus.mem_ack = 1'b1; bus.mem_data = 32'h0BAD0BAE;
      tick();
      bus.mem_ack = 1'b0; bus.mem_data = '0;
      tick();
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_data01", {bus.l0_data, bus.l1_data}, 64'd0);
      chk("rst_data2", 64'(bus.l2_data), 64'd0);
      chk("rst_no_rdy", 64'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] - c0 - c1 - c2), 64'd0);

      // last_grant back at 2: pending layers 1 and 2 are served 1 then 2.
      pulse3(3'b110, 22'h0, 22'h7, 22'h8);
      serve(1, 25'h100007, 32'hE1E1E1E1);
      serve(2, 25'h100008, 32'hE2E2E2E2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ga23_sdr_arbiter.md
# ga23_sdr_arbiter

Multiplexes the tile-row SDRAM fetches of the three GA23 background layers onto one SDRAM read port. Each layer issues a one-cycle request pulse carrying a 22-bit tile-row byte address. The arbiter queues one request per layer and serves them round-robin. It returns the 32-bit row to the requesting layer with a one-cycle ready pulse. It sits between the three layer instances and the board SDRAM controller's GFX read channel.

## Interface
Parameters:
- BASE_ADDR, 25'h0, byte offset of the tile ROM region in SDRAM; added to every layer address.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- lN_req  in  1  (N=0,1,2) one-cycle request pulse from layer N.
- lN_addr  in  22  layer N tile-row byte address; valid while lN_req=1.
- lN_data  out  32  last row fetched for layer N; held until the next completion for N.
- lN_rdy  out  1  one-cycle pulse; lN_data was updated on this edge.
- mem_req  out  1  read request to SDRAM; level, held until acknowledged.
- mem_addr  out  25  read byte address = BASE_ADDR + {3'b0, latched lN_addr}, modulo 2^25.
- mem_ack  in  1  one-cycle pulse; mem_data is valid in the same cycle.
- mem_data  in  32  read data.

## Operation
- Per-layer state:
  - pend[N]: request waiting.
  - addr_q[N]: 22-bit latched address.
- Request capture: lN_req=1 sets pend[N] and loads addr_q[N] from lN_addr. A request that arrives while pend[N] is already set overwrites addr_q[N]; only the latest address is fetched. Requests are not counted.
- FSM, 2 states:
  - IDLE: if any pend bit is set, grant one layer by round-robin. Search starts at the layer after last_grant, wrapping 2->0. Grant actions: set cur=N, clear pend[N], drive mem_addr from addr_q[N], assert mem_req, go to BUSY. If no pend bit is set, stay in IDLE with mem_req=0.
  - BUSY: mem_req and mem_addr are held constant. On mem_ack:
    - load lN_data[cur] from mem_data;
    - pulse lN_rdy[cur];
    - set last_grant=cur;
    - deassert mem_req;
    - return to IDLE.
- A request for layer cur that arrives while it is in flight sets pend[cur] again. That request is fetched after the current one completes and is not merged into it.
- Request and grant on the same edge for the same layer: the grant uses the old addr_q and clears pend. The new request then sets pend again, so set wins over clear. The new address is served later.
- mem_ack in IDLE is ignored: no data update and no rdy pulse.
- Unacknowledged requests have no timeout. mem_req stays high until mem_ack.

## Timing
- Reset values:
  - FSM = IDLE;
  - pend = 0, addr_q = 0, cur = 0;
  - last_grant = 2, so the first grant search starts at layer 0;
  - mem_req = 0, mem_addr = 0;
  - all lN_data = 0, all lN_rdy = 0.
- Reset asserted mid-transfer aborts the transfer. No rdy pulse is produced. A mem_ack that arrives after reset is released is ignored because the FSM is in IDLE.
- Request-to-grant: lN_req sampled at edge E sets pend. With the FSM idle, mem_req=1 and a valid mem_addr are visible after edge E+1.
- Completion: mem_ack sampled at edge A. lN_data and lN_rdy update after A, and lN_rdy is high for exactly one cycle. mem_req=0 after A.
- Back-to-back: the next grant occurs at edge A+1. mem_req is therefore low for at least one cycle between transfers.
- Minimum request-to-rdy latency: 2 cycles plus the SDRAM latency, measured edge E to edge A, with A ≥ E+2.
- Worst case for a single layer: the two other layers are served before it. Layers must issue their requests early enough to absorb three SDRAM latencies before they use the data at the next tile load.

## Test plan
- Single request: l1_req with l1_addr=22'h12344, BASE_ADDR=25'h100000.
  - mem_req rises one cycle later with mem_addr=25'h112344.
  - mem_ack with mem_data=32'hDEADBEEF gives l1_data=32'hDEADBEEF and a single l1_rdy pulse. l0 and l2 outputs are unchanged.
- Round-robin: l0, l1 and l2 requests in the same cycle, with acks after 3 cycles each.
  - Grant order is 0,1,2. mem_req drops for one cycle between grants.
  - A second simultaneous burst after last_grant=2 is again served 0,1,2.
- Overwrite: l2_req addr=22'h00100, then l2_req addr=22'h00200 while layer 0 is in flight. Layer 2 is fetched once, with the address offset 22'h00200.
- In-flight re-request: l0_req while layer 0 is BUSY. After the ack, layer 0 is granted again with the new address, and two l0_rdy pulses occur in total.
- Same-edge set/clear: l1_req on the edge where layer 1 is granted from IDLE. The first fetch uses the old address; a second fetch follows with the new one.
- Reset mid-transfer: assert reset in BUSY, release it, then pulse mem_ack.
  - No rdy pulse occurs, and all outputs are at their reset values.
  - Stray mem_ack pulses in IDLE leave all lN_data unchanged.
